hazard_stall_unit: RTL and testbench

- Producer-side companion to the pipeline forwarding logic.
- Detects data hazards that forwarding cannot cover (load-use, and branch/JR resolved in ID).
- Drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush on taken branches or jumps.
- Sits in ID alongside the forwarding unit; holds a small stall FSM and performance counters.

---
 rtl/hazard_stall_unit_pkg.sv | 28 ++
 rtl/hazard_stall_unit_if.sv | 38 +++
 rtl/hazard_stall_unit_match.sv | 46 ++++
 rtl/hazard_stall_unit.sv | 120 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall logic.
// Holds register-index constants, FSM encodings, hazard classes and the NOP bubble encoding.
package hazard_stall_unit_pkg;

  localparam int          REG_W     = 5;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    HZ_NONE       = 2'd0,
    HZ_LOAD_USE   = 2'd1,
    HZ_EX_BRANCH  = 2'd2,
    HZ_MEM_BRANCH = 2'd3
  } hazard_t;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic srcMatch(input logic uses,
                                    input logic [REG_W-1:0] srcReg,
                                    input logic [REG_W-1:0] dstReg);
    return uses && (srcReg == dstReg) && (dstReg != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of ID/EX/MEM hazard inputs and the stall/flush control outputs.
// The stall unit takes the slave modport; the pipeline side takes the master modport.
interface hazard_stall_unit_if #(parameter int CNT_WIDTH = 32);
  import hazard_stall_unit_pkg::*;

  logic [REG_W-1:0]   IDU_RsReg;
  logic [REG_W-1:0]   IDU_RtReg;
  logic               IDU_UsesRs;
  logic               IDU_UsesRt;
  logic               IDU_IsBranch;
  logic               IDU_BranchTaken;
  logic [REG_W-1:0]   EXU_DestReg;
  logic               EXU_RegWrite;
  logic               EXU_MemRead;
  logic [REG_W-1:0]   MEM_DestReg;
  logic               MEM_MemRead;
  logic               MemStall;
  logic               PCWrite;
  logic               IFID_Write;
  logic               IFID_Flush;
  logic               IDEX_Bubble;
  logic               PipeHold;
  logic [CNT_WIDTH-1:0] StallCycles;
  logic [CNT_WIDTH-1:0] FlushCount;

  modport master (
    output IDU_RsReg, IDU_RtReg, IDU_UsesRs, IDU_UsesRt, IDU_IsBranch, IDU_BranchTaken,
    output EXU_DestReg, EXU_RegWrite, EXU_MemRead, MEM_DestReg, MEM_MemRead, MemStall,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold, StallCycles, FlushCount
  );

  modport slave (
    input  IDU_RsReg, IDU_RtReg, IDU_UsesRs, IDU_UsesRt, IDU_IsBranch, IDU_BranchTaken,
    input  EXU_DestReg, EXU_RegWrite, EXU_MemRead, MEM_DestReg, MEM_MemRead, MemStall,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold, StallCycles, FlushCount
  );

endinterface

// File: rtl/hazard_stall_unit_match.sv
// Combinational rs/rt comparator: classifies the hazard seen by the ID instruction
// and returns how many stall cycles it needs (0 when forwarding covers it).
module hazard_match
  import hazard_stall_unit_pkg::*;
#(
  parameter int LOAD_BRANCH_STALLS = 2
) (
  input  logic [REG_W-1:0] i_rsReg,
  input  logic [REG_W-1:0] i_rtReg,
  input  logic             i_usesRs,
  input  logic             i_usesRt,
  input  logic             i_isBranch,
  input  logic [REG_W-1:0] i_exDestReg,
  input  logic             i_exRegWrite,
  input  logic             i_exMemRead,
  input  logic [REG_W-1:0] i_memDestReg,
  input  logic             i_memMemRead,
  output hazard_t          o_hazard,
  output logic [1:0]       o_stallN
);

  logic w_exHit;
  logic w_memHit;

  assign w_exHit  = srcMatch(i_usesRs, i_rsReg, i_exDestReg)  ||
                    srcMatch(i_usesRt, i_rtReg, i_exDestReg);
  assign w_memHit = srcMatch(i_usesRs, i_rsReg, i_memDestReg) ||
                    srcMatch(i_usesRt, i_rtReg, i_memDestReg);

  // Load-use dominates: it alone can need more than one cycle.
  always_comb begin
    o_hazard = HZ_NONE;
    o_stallN = 2'd0;
    if (i_exMemRead && w_exHit) begin
      o_hazard = HZ_LOAD_USE;
      o_stallN = i_isBranch ? 2'(LOAD_BRANCH_STALLS) : 2'd1;
    end else if (i_isBranch && i_exRegWrite && !i_exMemRead && w_exHit) begin
      o_hazard = HZ_EX_BRANCH;
      o_stallN = 2'd1;
    end else if (i_isBranch && i_memMemRead && w_memHit) begin
      o_hazard = HZ_MEM_BRANCH;
      o_stallN = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall unit: inserts bubbles for hazards forwarding cannot cover,
// flushes IF/ID on taken branches, and counts stall cycles and flushes.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_WIDTH          = 32,
  parameter int LOAD_BRANCH_STALLS = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  hazard_stall_unit_if.slave  bus
);

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_stallLeft;
  logic [1:0]           w_nextStallLeft;
  logic [CNT_WIDTH-1:0] r_stallCycles;
  logic [CNT_WIDTH-1:0] r_flushCount;
  hazard_t              w_hazard;
  logic [1:0]           w_stallN;
  logic                 w_incStall;
  logic                 w_incFlush;
  logic                 w_pcWrite;
  logic                 w_ifidWrite;
  logic                 w_ifidFlush;
  logic                 w_idexBubble;
  logic                 w_pipeHold;

  hazard_match #(
    .LOAD_BRANCH_STALLS (LOAD_BRANCH_STALLS)
  ) u_match (
    .i_rsReg      (bus.IDU_RsReg),
    .i_rtReg      (bus.IDU_RtReg),
    .i_usesRs     (bus.IDU_UsesRs),
    .i_usesRt     (bus.IDU_UsesRt),
    .i_isBranch   (bus.IDU_IsBranch),
    .i_exDestReg  (bus.EXU_DestReg),
    .i_exRegWrite (bus.EXU_RegWrite),
    .i_exMemRead  (bus.EXU_MemRead),
    .i_memDestReg (bus.MEM_DestReg),
    .i_memMemRead (bus.MEM_MemRead),
    .o_hazard     (w_hazard),
    .o_stallN     (w_stallN)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= ST_RUN;
      r_stallLeft   <= 2'd0;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_stallLeft <= w_nextStallLeft;
      if (w_incStall) r_stallCycles <= r_stallCycles + 1'b1;
      if (w_incFlush) r_flushCount  <= r_flushCount + 1'b1;
    end
  end

  // Reset outputs are driven combinationally so the pipeline is quiesced
  // for as long as Reset_n is low; MemStall freezes everything else.
  always_comb begin
    w_nextState     = r_state;
    w_nextStallLeft = r_stallLeft;
    w_pcWrite       = 1'b1;
    w_ifidWrite     = 1'b1;
    w_ifidFlush     = 1'b0;
    w_idexBubble    = 1'b0;
    w_pipeHold      = 1'b0;
    w_incStall      = 1'b0;
    w_incFlush      = 1'b0;
    if (!Reset_n) begin
      w_pcWrite    = 1'b0;
      w_ifidWrite  = 1'b0;
      w_ifidFlush  = 1'b1;
      w_idexBubble = 1'b1;
    end else if (bus.MemStall) begin
      w_pipeHold  = 1'b1;
      w_pcWrite   = 1'b0;
      w_ifidWrite = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard != HZ_NONE) begin
            w_pcWrite    = 1'b0;
            w_ifidWrite  = 1'b0;
            w_idexBubble = 1'b1;
            w_incStall   = 1'b1;
            if (w_stallN > 2'd1) begin
              w_nextState     = ST_STALL;
              w_nextStallLeft = w_stallN - 2'd1;
            end
          end else begin
            w_ifidFlush = bus.IDU_BranchTaken;
            w_incFlush  = bus.IDU_BranchTaken;
          end
        end
        ST_STALL: begin
          w_pcWrite       = 1'b0;
          w_ifidWrite     = 1'b0;
          w_idexBubble    = 1'b1;
          w_incStall      = 1'b1;
          w_nextStallLeft = r_stallLeft - 2'd1;
          if (r_stallLeft == 2'd1) w_nextState = ST_RUN;
        end
        default: w_nextState = ST_RUN;
      endcase
    end
  end

  assign bus.PCWrite     = w_pcWrite;
  assign bus.IFID_Write  = w_ifidWrite;
  assign bus.IFID_Flush  = w_ifidFlush;
  assign bus.IDEX_Bubble = w_idexBubble;
  assign bus.PipeHold    = w_pipeHold;
  assign bus.StallCycles = r_stallCycles;
  assign bus.FlushCount  = r_flushCount;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic,
// checked against a cycle-count reference model of the stall/flush rules.
module tb_hazard_stall_unit;

  localparam int CW  = 32;
  localparam int LBS = 2;

  typedef struct packed {
    logic       rstN;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       isBr;
    logic       taken;
    logic [4:0] exDst;
    logic       exRw;
    logic       exMr;
    logic [4:0] memDst;
    logic       memMr;
    logic       memStall;
  } stim_t;

  typedef struct packed {
    logic          pcWrite;
    logic          ifidWrite;
    logic          flush;
    logic          bubble;
    logic          hold;
    logic [CW-1:0] stallCycles;
    logic [CW-1:0] flushCount;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n;

  hazard_stall_unit_if #(.CNT_WIDTH(CW)) bus ();

  hazard_stall_unit #(
    .CNT_WIDTH          (CW),
    .LOAD_BRANCH_STALLS (LBS)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  exp_t    expQ[$];
  int      errors = 0;
  int      checks = 0;
  int      pushed = 0;
  int      popped = 0;

  // Reference model: remaining forced stall cycles plus the two event counts.
  int          pendStalls = 0;
  logic [CW-1:0] mStall = '0;
  logic [CW-1:0] mFlush = '0;

  function automatic logic hit(stim_t s, logic [4:0] d);
    return d != 5'd0 && ((s.usesRs && s.rs == d) || (s.usesRt && s.rt == d));
  endfunction

  function automatic int stallsNeeded(stim_t s);
    if (s.exMr && hit(s, s.exDst)) return s.isBr ? LBS : 1;
    if (s.isBr && s.exRw && !s.exMr && hit(s, s.exDst)) return 1;
    if (s.isBr && s.memMr && hit(s, s.memDst)) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle, push what the outputs must show during it, then advance the model.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   n;
    @(posedge Clk);
    #1;
    Reset_n             = s.rstN;
    bus.IDU_RsReg       = s.rs;
    bus.IDU_RtReg       = s.rt;
    bus.IDU_UsesRs      = s.usesRs;
    bus.IDU_UsesRt      = s.usesRt;
    bus.IDU_IsBranch    = s.isBr;
    bus.IDU_BranchTaken = s.taken;
    bus.EXU_DestReg     = s.exDst;
    bus.EXU_RegWrite    = s.exRw;
    bus.EXU_MemRead     = s.exMr;
    bus.MEM_DestReg     = s.memDst;
    bus.MEM_MemRead     = s.memMr;
    bus.MemStall        = s.memStall;
    if (!s.rstN) begin
      pendStalls = 0;
      mStall = '0;
      mFlush = '0;
      e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mStall, mFlush};
    end else if (s.memStall) begin
      e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mStall, mFlush};
    end else if (pendStalls > 0) begin
      e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mStall, mFlush};
      pendStalls--;
      mStall++;
    end else begin
      n = stallsNeeded(s);
      if (n > 0) begin
        e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mStall, mFlush};
        pendStalls = n - 1;
        mStall++;
      end else begin
        e = '{1'b1, 1'b1, s.taken, 1'b0, 1'b0, mStall, mFlush};
        if (s.taken) mFlush++;
      end
    end
    expQ.push_back(e);
    pushed++;
  endtask

  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      popped++;
      checkOutput("PCWrite",     CW'(bus.PCWrite),     CW'(e.pcWrite));
      checkOutput("IFID_Write",  CW'(bus.IFID_Write),  CW'(e.ifidWrite));
      checkOutput("IFID_Flush",  CW'(bus.IFID_Flush),  CW'(e.flush));
      checkOutput("IDEX_Bubble", CW'(bus.IDEX_Bubble), CW'(e.bubble));
      checkOutput("PipeHold",    CW'(bus.PipeHold),    CW'(e.hold));
      checkOutput("StallCycles", bus.StallCycles,      e.stallCycles);
      checkOutput("FlushCount",  bus.FlushCount,       e.flushCount);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s, lwAdd, lwBeq;
    Reset_n = 1'b0;
    bus.IDU_RsReg = '0; bus.IDU_RtReg = '0; bus.IDU_UsesRs = 0; bus.IDU_UsesRt = 0;
    bus.IDU_IsBranch = 0; bus.IDU_BranchTaken = 0; bus.EXU_DestReg = '0;
    bus.EXU_RegWrite = 0; bus.EXU_MemRead = 0; bus.MEM_DestReg = '0;
    bus.MEM_MemRead = 0; bus.MemStall = 0;

    s = idle(); s.rstN = 1'b0;
    applyStimulus(s);
    applyStimulus(s);

    lwAdd = idle();
    lwAdd.rs = 5'd8; lwAdd.usesRs = 1; lwAdd.exDst = 5'd8; lwAdd.exRw = 1; lwAdd.exMr = 1;
    applyStimulus(lwAdd);
    applyStimulus(idle());

    lwBeq = lwAdd;
    lwBeq.isBr = 1; lwBeq.taken = 1;
    applyStimulus(lwBeq);
    applyStimulus(lwBeq);
    applyStimulus(idle());

    s = lwAdd; s.rs = 5'd0; s.exDst = 5'd0;
    applyStimulus(s);

    s = idle(); s.isBr = 1; s.taken = 1;
    applyStimulus(s);

    applyStimulus(lwBeq);
    s = lwBeq; s.memStall = 1;
    repeat (3) applyStimulus(s);
    applyStimulus(lwBeq);
    applyStimulus(idle());

    applyStimulus(lwBeq);
    s = lwBeq; s.rstN = 1'b0;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.isBr = 1; s.taken = 1;
    applyStimulus(s);

    for (int i = 0; i < 3000; i++) begin
      s.rstN     = ($urandom_range(0, 99) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.usesRs   = 1'($urandom);
      s.usesRt   = 1'($urandom);
      s.isBr     = 1'($urandom);
      s.taken    = 1'($urandom);
      s.exDst    = 5'($urandom_range(0, 3));
      s.exRw     = 1'($urandom);
      s.exMr     = 1'($urandom);
      s.memDst   = 5'($urandom_range(0, 3));
      s.memMr    = 1'($urandom);
      s.memStall = ($urandom_range(0, 6) == 0);
      applyStimulus(s);
    end

    repeat (3) @(posedge Clk);
    checkOutput("scoreboard_drained", CW'(popped), CW'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
